// File: rtl/ps2_note_decoder.sv
// PS/2 set-2 scancode to 32-note held-key bitmap decoder.
// Tracks F0/E0 prefixes with a timeout and emits per-event strobes.
module ps2_note_decoder #(
  parameter int unsigned PREFIX_TIMEOUT = 2500000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [7:0]  ps2_byte,
  input  logic        ps2_byte_valid,
  output logic [31:0] keyPressed,
  output logic        key_event,
  output logic [4:0]  key_index,
  output logic        key_make,
  output logic [5:0]  num_pressed,
  output logic        seq_error
);

  typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] map_q, map_d;
  logic        ev_q, ev_d;
  logic [4:0]  idx_q, idx_d;
  logic        mk_q, mk_d;
  logic [5:0]  pc_q, pc_d;
  logic        err_q, err_d;

  logic        hit;
  logic [4:0]  note;
  logic        bad_byte;
  logic        timeout;

  always_comb begin
    hit  = 1'b1;
    note = '0;
    case (ps2_byte)
      8'h1A: note = 5'd0;   8'h1B: note = 5'd1;   8'h22: note = 5'd2;   8'h23: note = 5'd3;
      8'h21: note = 5'd4;   8'h2A: note = 5'd5;   8'h34: note = 5'd6;   8'h32: note = 5'd7;
      8'h33: note = 5'd8;   8'h31: note = 5'd9;   8'h3B: note = 5'd10;  8'h3A: note = 5'd11;
      8'h41: note = 5'd12;  8'h4B: note = 5'd13;  8'h49: note = 5'd14;  8'h4C: note = 5'd15;
      8'h4A: note = 5'd16;  8'h15: note = 5'd17;  8'h1E: note = 5'd18;  8'h1D: note = 5'd19;
      8'h26: note = 5'd20;  8'h24: note = 5'd21;  8'h2D: note = 5'd22;  8'h2E: note = 5'd23;
      8'h2C: note = 5'd24;  8'h36: note = 5'd25;  8'h35: note = 5'd26;  8'h3D: note = 5'd27;
      8'h3C: note = 5'd28;  8'h43: note = 5'd29;  8'h46: note = 5'd30;  8'h44: note = 5'd31;
      default: hit = 1'b0;
    endcase
  end

  assign bad_byte = (ps2_byte == 8'h00) || (ps2_byte == 8'hFF);
  // A valid byte in the same cycle always pre-empts the timeout.
  assign timeout  = !ps2_byte_valid && (state_q != IDLE) &&
                    (cnt_q == PREFIX_TIMEOUT - 32'd1);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      map_q   <= '0;
      ev_q    <= 1'b0;
      idx_q   <= '0;
      mk_q    <= 1'b0;
      pc_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      map_q   <= map_d;
      ev_q    <= ev_d;
      idx_q   <= idx_d;
      mk_q    <= mk_d;
      pc_q    <= pc_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (ps2_byte_valid) begin
      cnt_d = '0;
      if (bad_byte) begin
        state_d = IDLE;
      end else begin
        case (state_q)
          IDLE:    state_d = (ps2_byte == 8'hF0) ? BRK :
                             (ps2_byte == 8'hE0) ? EXT : IDLE;
          EXT:     state_d = (ps2_byte == 8'hF0) ? EXT_BRK : IDLE;
          default: state_d = IDLE;
        endcase
      end
    end else if (timeout) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (state_q != IDLE) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_comb begin
    map_d = map_q;
    ev_d  = 1'b0;
    idx_d = idx_q;
    mk_d  = mk_q;
    err_d = timeout;
    if (ps2_byte_valid) begin
      if (bad_byte) begin
        map_d = '0;
        err_d = 1'b1;
      end else if (state_q == IDLE) begin
        if (hit && !map_q[note]) begin
          map_d[note] = 1'b1;
          ev_d        = 1'b1;
          idx_d       = note;
          mk_d        = 1'b1;
        end else if (ps2_byte == 8'h76 || ps2_byte == 8'hAA) begin
          map_d = '0;
        end
      end else if (state_q == BRK) begin
        if (hit && map_q[note]) begin
          map_d[note] = 1'b0;
          ev_d        = 1'b1;
          idx_d       = note;
          mk_d        = 1'b0;
        end
      end
    end
    pc_d = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      pc_d = pc_d + {5'd0, map_d[i]};
    end
  end

  assign keyPressed  = map_q;
  assign key_event   = ev_q;
  assign key_index   = idx_q;
  assign key_make    = mk_q;
  assign num_pressed = pc_q;
  assign seq_error   = err_q;

endmodule

// File: tb/tb_ps2_note_decoder.sv
// Randomised bench for ps2_note_decoder against a prefix-queue reference model.
module tb_ps2_note_decoder;

  localparam int unsigned T = 16;

  logic        clk = 1'b0;
  logic        resetn;
  logic [7:0]  ps2_byte;
  logic        ps2_byte_valid;
  logic [31:0] keyPressed;
  logic        key_event;
  logic [4:0]  key_index;
  logic        key_make;
  logic [5:0]  num_pressed;
  logic        seq_error;

  ps2_note_decoder #(.PREFIX_TIMEOUT(T)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .ps2_byte       (ps2_byte),
    .ps2_byte_valid (ps2_byte_valid),
    .keyPressed     (keyPressed),
    .key_event      (key_event),
    .key_index      (key_index),
    .key_make       (key_make),
    .num_pressed    (num_pressed),
    .seq_error      (seq_error)
  );

  always #5 clk = ~clk;

  logic [7:0] NOTES [32] = '{8'h1A, 8'h1B, 8'h22, 8'h23, 8'h21, 8'h2A, 8'h34, 8'h32,
                             8'h33, 8'h31, 8'h3B, 8'h3A, 8'h41, 8'h4B, 8'h49, 8'h4C,
                             8'h4A, 8'h15, 8'h1E, 8'h1D, 8'h26, 8'h24, 8'h2D, 8'h2E,
                             8'h2C, 8'h36, 8'h35, 8'h3D, 8'h3C, 8'h43, 8'h46, 8'h44};

  // Reference model: held-note set, queue of pending prefix bytes, idle counter.
  logic [31:0] m_held;
  logic        m_ev, m_err, m_mk;
  logic [4:0]  m_idx;
  logic [7:0]  pend [$];
  int unsigned idle;

  int tests = 0;
  int fails = 0;
  int ev_count = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0 ] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int note_of(input logic [7:0] b);
    for (int i = 0; i < 32; i++) if (NOTES[i] == b) return i;
    return -1;
  endfunction

  task automatic model(input logic v, input logic [7:0] b);
    int n;
    m_ev  = 1'b0;
    m_err = 1'b0;
    if (!resetn) begin
      m_held = '0; m_idx = '0; m_mk = 1'b0; pend.delete(); idle = 0;
      return;
    end
    if (v) begin
      idle = 0;
      n = note_of(b);
      if (b == 8'h00 || b == 8'hFF) begin
        m_held = '0; m_err = 1'b1; pend.delete();
      end else if (pend.size() == 0) begin
        if (b == 8'hF0 || b == 8'hE0) pend.push_back(b);
        else if (n >= 0) begin
          if (!m_held[n]) begin
            m_held[n] = 1'b1; m_ev = 1'b1; m_idx = 5'(n); m_mk = 1'b1;
          end
        end else if (b == 8'h76 || b == 8'hAA) m_held = '0;
      end else if (pend.size() == 1 && pend[0] == 8'hF0) begin
        if (n >= 0 && m_held[n]) begin
          m_held[n] = 1'b0; m_ev = 1'b1; m_idx = 5'(n); m_mk = 1'b0;
        end
        pend.delete();
      end else if (pend.size() == 1 && pend[0] == 8'hE0 && b == 8'hF0) begin
        pend.push_back(b);
      end else begin
        pend.delete();
      end
    end else if (pend.size() > 0) begin
      idle++;
      if (idle == T) begin
        m_err = 1'b1; pend.delete(); idle = 0;
      end
    end
  endtask

  task automatic cyc(input logic v, input logic [7:0] b);
    @(negedge clk);
    ps2_byte_valid = v;
    ps2_byte       = b;
    @(posedge clk);
    model(v, b);
    #1;
    if (key_event) ev_count++;
    chk("keyPressed",  keyPressed, m_held);
    chk("num_pressed", 32'(num_pressed), 32'($countones(m_held)));
    chk("key_event",   32'(key_event), 32'(m_ev));
    chk("seq_error",   32'(seq_error), 32'(m_err));
    chk("key_index",   32'(key_index), 32'(m_idx));
    chk("key_make",    32'(key_make), 32'(m_mk));
  endtask

  task automatic send(input logic [7:0] b);
    cyc(1'b1, b);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00);
  endtask

  initial begin
    int ev_before;
    int k;
    logic [7:0] b;
    resetn = 1'b0; ps2_byte_valid = 1'b0; ps2_byte = '0;
    m_held = '0; m_idx = '0; m_mk = 1'b0; idle = 0;
    cyc(1'b0, 8'h00);
    cyc(1'b0, 8'h00);
    resetn = 1'b1;
    idle_cycles(1);

    // Make/break of note 0
    send(8'h1A);
    chk("make0_event", 32'(key_event), 32'd1);
    send(8'hF0); send(8'h1A);
    chk("brk0_map", keyPressed, 32'd0);

    // Typematic repeats of note 31 give one event
    ev_before = ev_count;
    send(8'h44); send(8'h44); send(8'h44);
    chk("typematic_events", 32'(ev_count - ev_before), 32'd1);
    chk("typematic_map", keyPressed, 32'h8000_0000);
    send(8'hF0); send(8'h44);

    // Three notes then Esc
    send(8'h15); send(8'h1E); send(8'h1D);
    chk("three_map", keyPressed, 32'h000E_0000);
    send(8'h76);
    chk("esc_map", keyPressed, 32'd0);

    // Extended codes never touch the map
    send(8'h1A);
    send(8'hE0); send(8'h1A);
    send(8'hE0); send(8'hF0); send(8'h1A);
    chk("ext_map", keyPressed, 32'd1);
    send(8'hF0); send(8'h1A);
    chk("ext_then_brk", keyPressed, 32'd0);

    // Error byte and prefix timeout
    send(8'h1A); send(8'h2A);
    send(8'hFF);
    chk("ff_err", 32'(seq_error), 32'd1);
    send(8'hF0);
    idle_cycles(T + 2);
    send(8'h1A);
    chk("after_timeout_make", keyPressed, 32'd1);

    // Reset mid-prefix
    send(8'hF0);
    resetn = 1'b0;
    cyc(1'b0, 8'h00);
    resetn = 1'b1;
    send(8'h1A);
    chk("post_reset_make", 32'(key_make), 32'd1);

    // Randomised traffic, including back-to-back bytes and long gaps
    for (int i = 0; i < 2500; i++) begin
      k = int'($urandom_range(0, 99));
      if (k < 50)      b = NOTES[$urandom_range(0, 31)];
      else if (k < 68) b = 8'hF0;
      else if (k < 76) b = 8'hE0;
      else if (k < 79) b = 8'h76;
      else if (k < 81) b = 8'hAA;
      else if (k < 83) b = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
      else             b = 8'($urandom);
      send(b);
      k = int'($urandom_range(0, 99));
      if (k < 60)      ;
      else if (k < 92) idle_cycles(int'($urandom_range(1, 3)));
      else if (k < 98) idle_cycles(int'($urandom_range(T - 2, T + 2)));
      else begin
        resetn = 1'b0;
        cyc(1'b0, 8'h00);
        resetn = 1'b1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ps2_note_decoder.md
Name: ps2_note_decoder

Overview:
- Upstream stage of the 32-key square-wave synthesiser: converts PS/2 set-2 scancode bytes into the 32-bit held-key bitmap `keyPressed` that drives the tone generators.
- Tracks make/break/extended prefixes, handles keyboard reset and error codes, and emits per-event strobes for status logic.

Parameters:
- PREFIX_TIMEOUT, 2500000, clk cycles a pending prefix (F0/E0) may wait for its next byte before being discarded (50 ms at 50 MHz).

Ports:
- clk  in  1  system clock
- resetn  in  1  synchronous active-low reset
- ps2_byte  in  8  received scancode byte
- ps2_byte_valid  in  1  one-cycle strobe, ps2_byte valid
- keyPressed  out  32  bit i = note i held (bit 0 lowest pitch)
- key_event  out  1  one-cycle pulse, a mapped key changed state
- key_index  out  5  note index of last key_event
- key_make  out  1  1 = press, 0 = release, for last key_event
- num_pressed  out  6  popcount of keyPressed (0..32)
- seq_error  out  1  one-cycle pulse, error/overrun byte or prefix timeout

Behaviour:
- Reset (resetn=0 at posedge clk): keyPressed=0, num_pressed=0, key_event=0, seq_error=0, key_index=0, key_make=0, state=IDLE, timeout counter=0. Reset mid-sequence discards any pending prefix.
- Note map, index 0..31 in order, set-2 codes: 1A 1B 22 23 21 2A 34 32 33 31 3B 3A 41 4B 49 4C 4A 15 1E 1D 26 24 2D 2E 2C 36 35 3D 3C 43 46 44 (Z S X D C V G B H N J M , L . ; / Q 2 W 3 E R 5 T 6 Y 7 U I 9 O).
- States: IDLE, BRK (F0 seen), EXT (E0 seen), EXT_BRK (E0 F0 seen). Transitions occur only on ps2_byte_valid, except timeout.
- IDLE:
  - F0 -> BRK.
  - E0 -> EXT.
  - Mapped code -> set bit. key_event pulses only if the bit was 0, so typematic repeats are silent.
  - 76 (Esc) -> clear all bits, no key_event.
  - AA (BAT) -> clear all bits.
  - Other codes ignored.
- BRK: mapped code -> clear bit, key_event with key_make=0 only if the bit was 1. Any other byte except 00/FF is ignored. Next state is always IDLE.
- EXT: F0 -> EXT_BRK. Any other byte -> IDLE, no map change; extended keys are never notes.
- EXT_BRK: any byte -> IDLE, no map change.
- Bytes 00 or FF (overrun/error) in any state: clear map, seq_error pulse, go to IDLE.
- Timeout:
  - The counter runs only in BRK/EXT/EXT_BRK and clears on every valid byte and on entering IDLE.
  - When it reaches PREFIX_TIMEOUT-1: go to IDLE, seq_error pulse, map unchanged.
  - If a valid byte arrives the same cycle, the byte wins and no timeout fires.
- Latency: keyPressed, num_pressed, key_event, key_index, key_make and seq_error are all registered and update 1 cycle after the valid strobe. num_pressed always equals the popcount of the keyPressed value output in the same cycle.
- key_index and key_make hold their values between events.
- Back-to-back valid strobes on consecutive cycles must each be processed.

Test Plan:
- Reset, then bytes 1A -> keyPressed=0x00000001, key_event pulse, key_index=0, key_make=1, num_pressed=1. Then F0,1A -> keyPressed=0, key_event, key_make=0, num_pressed=0.
- Make 44 three times (typematic) -> bit31 set after the first byte, exactly one key_event, num_pressed=1. Then F0,44 -> 0.
- Make 15, 1E, 1D -> keyPressed=0x000E0000, num_pressed=3. Then 76 -> keyPressed=0, num_pressed=0, no key_event.
- With bit 0 set: E0,1A and E0,F0,1A -> map unchanged, no key_event, state IDLE. Then F0,1A still clears bit 0.
- With bits 0 and 5 set: byte FF -> keyPressed=0, seq_error pulse. Byte F0 followed by no byte for PREFIX_TIMEOUT cycles (use PREFIX_TIMEOUT=16) -> seq_error pulse. A following 1A then sets bit 0 (treated as a make, not a break).
- Send F0, and assert resetn=0 on the next cycle. After release, byte 1A -> bit 0 set, key_make=1.
